escaner_teclado_4x4: RTL
========================

Name: escaner_teclado_4x4

Overview:
Input-side counterpart of the multiplexed 7-segment display controller: where the display time-multiplexes anodes outward, this block time-multiplexes keypad rows outward and reads columns back. It scans a 4x4 matrix keypad, debounces presses and emits a 4-bit key code with a one-cycle valid strobe. It also keeps a 4-digit entry buffer whose nibbles connect directly to the display controller's four data inputs.

Parameters:
P_DIV, 50000, i_Clk cycles per row period (scan tick interval); legal range >= 4
P_DEB, 4, consecutive identical full-matrix frames required to accept a press or a release; legal range >= 1

Ports:
i_Clk  input  1  system clock
i_Rst  input  1  reset, asynchronous, active-high
i_Columnas  input  4  keypad columns, active-low, externally pulled up, asynchronous to i_Clk
i_Borrar  input  1  synchronous clear of the digit buffer, active-high
o_Filas  output  4  keypad row drive, active-low, exactly one bit low at all times
o_Tecla  output  4  code of the last accepted key
o_Valida  output  1  one-cycle pulse when a press is accepted
o_Presionada  output  1  high while a debounced key is held
o_Digito1  output  4  newest entered digit
o_Digito2  output  4  previous digit
o_Digito3  output  4  digit before o_Digito2
o_Digito4  output  4  oldest digit

Behaviour:
- Reset (asynchronous, active-high): o_Filas=4'b1110 (row 0), o_Tecla=0, o_Valida=0, o_Presionada=0, o_Digito1..4=0, prescaler=0, FSM=IDLE, all counters=0, synchronizer flops=4'b1111.
- Synchronizer: i_Columnas passes through two flops before any use.
- Prescaler: counts 0..P_DIV-1 and asserts a one-cycle tick at P_DIV-1, then wraps to 0.
- Row scan: on each tick, the synchronized columns are sampled for the current row, then o_Filas rotates to the next row (1110 -> 1101 -> 1011 -> 0111 -> 1110). Sampling happens at the end of each row period, so the columns have P_DIV-1 cycles to settle, including synchronizer latency.
- Frame: 4 ticks, rows 0..3. A pressed key reads as column bit c = 0 while row r is driven.
- Key code: code = 4*r + c. When several keys are pressed, the lowest code in the frame wins. A frame with no column low is NONE.
- Frame result is evaluated on the tick that samples row 3.
- FSM, evaluated once per frame:
  - IDLE: a non-NONE frame loads cand=code, cnt=1, then goes to PRESS_DEB (or straight to accept if P_DEB=1).
  - PRESS_DEB:
    - Frame code == cand: cnt++. When cnt reaches P_DEB, accept.
    - Frame code differs but is non-NONE: cand=code, cnt=1.
    - Frame is NONE: return to IDLE.
  - Accept: o_Tecla<=cand, o_Valida=1 for exactly one i_Clk cycle (the cycle after the frame-final tick), o_Presionada<=1, state HELD.
  - HELD: a NONE frame loads cnt=1 and goes to REL_DEB (or straight to IDLE if P_DEB=1). A non-NONE frame stays in HELD, so there is no rollover: a different key while one is held is ignored.
  - REL_DEB:
    - NONE frame: cnt++. At P_DEB, go to IDLE and set o_Presionada<=0.
    - Non-NONE frame: return to HELD.
- Digit buffer: on accept, o_Digito4<=o_Digito3, o_Digito3<=o_Digito2, o_Digito2<=o_Digito1, o_Digito1<=cand. Shifting happens in the same cycle o_Valida is high.
- i_Borrar: clears all four digits on the next edge. It does not affect the FSM, o_Tecla or scanning. If i_Borrar coincides with an accept, the clear wins (digits=0) but o_Valida and o_Tecla still update.
- Press latency from stable contact: at most P_DEB+1 frames plus 3 cycles.
- Reset asserted mid-scan or mid-debounce returns everything to reset values immediately. A key held through reset release must be re-debounced from IDLE.

Test Plan:
- Reset with i_Columnas=4'b0000 -> o_Filas=4'b1110, all outputs 0; after release with P_DIV=4, o_Filas rotates every 4 cycles through 1101, 1011, 0111, 1110.
- P_DIV=4, P_DEB=3: hold row 2/col 1 for 5 frames -> a single o_Valida pulse, o_Tecla=4'd9, o_Digito1=9, o_Presionada=1 until 3 NONE frames after release.
- Bounce: key 5 alternates present/absent each frame for 6 frames -> no o_Valida pulse; then stable for 3 frames -> one pulse with o_Tecla=5.
- Keys 7, 0xA, 0x3, 0xF entered with releases between -> o_Digito4..1 = 7, A, 3, F; a fifth key 0x1 -> 0xA, 3, F, 1.
- Keys 6 and 0xB pressed together -> accepted code 6; while holding, release 6 but keep 0xB -> no new pulse until all keys are released and 0xB is pressed again.
- i_Borrar asserted in the o_Valida cycle -> digits all 0, o_Tecla=new code; i_Rst pulsed during PRESS_DEB -> no pulse, FSM restarts from IDLE.

Source files
------------

// File: rtl/escaner_teclado_4x4.sv
// 4x4 matrix keypad scanner.
// Drives one keypad row low at a time, reads the active-low columns back
// through a two-flop synchronizer, resolves one key code per full frame
// (lowest code wins), debounces presses and releases over P_DEB identical
// frames, and keeps a 4-digit shift buffer of accepted keys for the display.
module escaner_teclado_4x4 #(
    parameter int P_DIV = 50000,  // clock cycles per row period (>= 4)
    parameter int P_DEB = 4       // identical frames to accept press/release (>= 1)
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic [3:0] i_Columnas,
    input  logic       i_Borrar,
    output logic [3:0] o_Filas,
    output logic [3:0] o_Tecla,
    output logic       o_Valida,
    output logic       o_Presionada,
    output logic [3:0] o_Digito1,
    output logic [3:0] o_Digito2,
    output logic [3:0] o_Digito3,
    output logic [3:0] o_Digito4
);

    localparam int PRESC_W = $clog2(P_DIV);
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(P_DIV - 1);
    localparam logic [PRESC_W-1:0] PRESC_ZERO = PRESC_W'(0);
    localparam logic [PRESC_W-1:0] PRESC_ONE  = PRESC_W'(1);

    localparam int CNT_W = $clog2(P_DEB + 1);
    localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_TARGET = CNT_W'(P_DEB);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_PRESS_DEB = 2'd1,
        ST_HELD      = 2'd2,
        ST_REL_DEB   = 2'd3
    } state_t;

    // Column index of the lowest active-low column; only meaningful when
    // at least one column reads low.
    function automatic logic [1:0] lowest_zero_col(input logic [3:0] cols);
        logic [1:0] idx;
        if (!cols[0]) begin
            idx = 2'd0;
        end else if (!cols[1]) begin
            idx = 2'd1;
        end else if (!cols[2]) begin
            idx = 2'd2;
        end else begin
            idx = 2'd3;
        end
        return idx;
    endfunction

    // Synchronizer and scan state
    logic [3:0]         col_meta_r;
    logic [3:0]         col_sync_r;
    logic [PRESC_W-1:0] presc_r;
    logic               tick_s;
    logic [1:0]         row_idx_r;
    logic [3:0]         filas_r;

    // Frame accumulation
    logic               found_r;
    logic [3:0]         found_code_r;
    logic               row_hit_s;
    logic [3:0]         row_code_s;
    logic               frame_end_s;
    logic               frame_hit_s;
    logic [3:0]         frame_code_s;

    // Debounce FSM
    state_t             state_r;
    state_t             state_s;
    logic [3:0]         cand_r;
    logic [3:0]         cand_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [CNT_W-1:0]   cnt_s;
    logic [CNT_W-1:0]   cnt_inc_s;
    logic               accept_s;
    logic [3:0]         accept_code_s;
    logic               release_s;

    // Registered outputs
    logic [3:0]         tecla_r;
    logic               valida_r;
    logic               presionada_r;
    logic [3:0]         dig1_r;
    logic [3:0]         dig2_r;
    logic [3:0]         dig3_r;
    logic [3:0]         dig4_r;

    // Bring the asynchronous column lines into the clock domain.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            col_meta_r <= 4'b1111;
            col_sync_r <= 4'b1111;
        end else begin
            col_meta_r <= i_Columnas;
            col_sync_r <= col_meta_r;
        end
    end

    // Row-period prescaler: wraps at P_DIV-1, where the scan tick fires.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            presc_r <= PRESC_ZERO;
        end else if (tick_s) begin
            presc_r <= PRESC_ZERO;
        end else begin
            presc_r <= presc_r + PRESC_ONE;
        end
    end

    // Decode the tick, the current row result and the whole-frame result.
    always_comb begin
        tick_s       = (presc_r == PRESC_LAST);
        row_hit_s    = (col_sync_r != 4'b1111);
        row_code_s   = {row_idx_r, lowest_zero_col(col_sync_r)};
        frame_end_s  = tick_s && (row_idx_r == 2'd3);
        frame_hit_s  = found_r || row_hit_s;
        frame_code_s = found_r ? found_code_r : row_code_s;
    end

    // Rotate the active row on each tick and remember the first (lowest)
    // key seen in the frame; the memory clears once row 3 has been sampled.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            row_idx_r    <= 2'd0;
            filas_r      <= 4'b1110;
            found_r      <= 1'b0;
            found_code_r <= 4'd0;
        end else if (tick_s) begin
            row_idx_r <= row_idx_r + 2'd1;
            filas_r   <= {filas_r[2:0], filas_r[3]};
            if (row_idx_r == 2'd3) begin
                found_r <= 1'b0;
            end else if (!found_r && row_hit_s) begin
                found_r      <= 1'b1;
                found_code_r <= row_code_s;
            end
        end
    end

    // Debounce FSM state, candidate key and frame counter.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state_r <= ST_IDLE;
            cand_r  <= 4'd0;
            cnt_r   <= CNT_ZERO;
        end else begin
            state_r <= state_s;
            cand_r  <= cand_s;
            cnt_r   <= cnt_s;
        end
    end

    // Next-state logic, evaluated once per frame on the row-3 tick.
    always_comb begin
        state_s       = state_r;
        cand_s        = cand_r;
        cnt_s         = cnt_r;
        cnt_inc_s     = cnt_r + CNT_ONE;
        accept_s      = 1'b0;
        accept_code_s = cand_r;
        release_s     = 1'b0;
        if (frame_end_s) begin
            case (state_r)
                ST_IDLE: begin
                    if (frame_hit_s) begin
                        cand_s        = frame_code_s;
                        cnt_s         = CNT_ONE;
                        accept_code_s = frame_code_s;
                        if (CNT_ONE == CNT_TARGET) begin
                            accept_s = 1'b1;
                            state_s  = ST_HELD;
                        end else begin
                            state_s  = ST_PRESS_DEB;
                        end
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_PRESS_DEB: begin
                    if (!frame_hit_s) begin
                        state_s = ST_IDLE;
                    end else if (frame_code_s == cand_r) begin
                        cnt_s = cnt_inc_s;
                        if (cnt_inc_s == CNT_TARGET) begin
                            accept_s = 1'b1;
                            state_s  = ST_HELD;
                        end else begin
                            state_s  = ST_PRESS_DEB;
                        end
                    end else begin
                        // A different key restarts the debounce on that key.
                        cand_s  = frame_code_s;
                        cnt_s   = CNT_ONE;
                        state_s = ST_PRESS_DEB;
                    end
                end
                ST_HELD: begin
                    if (!frame_hit_s) begin
                        cnt_s = CNT_ONE;
                        if (CNT_ONE == CNT_TARGET) begin
                            release_s = 1'b1;
                            state_s   = ST_IDLE;
                        end else begin
                            state_s   = ST_REL_DEB;
                        end
                    end else begin
                        // No rollover: other keys are ignored while held.
                        state_s = ST_HELD;
                    end
                end
                ST_REL_DEB: begin
                    if (!frame_hit_s) begin
                        cnt_s = cnt_inc_s;
                        if (cnt_inc_s == CNT_TARGET) begin
                            release_s = 1'b1;
                            state_s   = ST_IDLE;
                        end else begin
                            state_s   = ST_REL_DEB;
                        end
                    end else begin
                        state_s = ST_HELD;
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                end
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // Key code, one-cycle valid strobe and held flag.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            tecla_r      <= 4'd0;
            valida_r     <= 1'b0;
            presionada_r <= 1'b0;
        end else begin
            valida_r <= accept_s;
            if (accept_s) begin
                tecla_r      <= accept_code_s;
                presionada_r <= 1'b1;
            end else if (release_s) begin
                presionada_r <= 1'b0;
            end
        end
    end

    // Digit entry buffer: newest key shifts in at Digito1; clear has priority.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            dig1_r <= 4'd0;
            dig2_r <= 4'd0;
            dig3_r <= 4'd0;
            dig4_r <= 4'd0;
        end else if (i_Borrar) begin
            dig1_r <= 4'd0;
            dig2_r <= 4'd0;
            dig3_r <= 4'd0;
            dig4_r <= 4'd0;
        end else if (accept_s) begin
            dig4_r <= dig3_r;
            dig3_r <= dig2_r;
            dig2_r <= dig1_r;
            dig1_r <= accept_code_s;
        end
    end

    assign o_Filas      = filas_r;
    assign o_Tecla      = tecla_r;
    assign o_Valida     = valida_r;
    assign o_Presionada = presionada_r;
    assign o_Digito1    = dig1_r;
    assign o_Digito2    = dig2_r;
    assign o_Digito3    = dig3_r;
    assign o_Digito4    = dig4_r;

endmodule
